// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding selects, load-use/scoreboard/structural stalls and multi-cycle unit tracking
module hazard_scoreboard #(
  parameter int REG_AW = 4,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic              dec_rs1_used,
  input  logic              dec_rs2_used,
  input  logic              dec_wr_en,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_is_mc,
  input  logic              flush,
  input  logic              reg_wr_enX,
  input  logic              reg_wr_enM,
  input  logic              reg_wr_enW,
  input  logic [REG_AW-1:0] write_regX,
  input  logic [REG_AW-1:0] write_regM,
  input  logic [REG_AW-1:0] write_regW,
  input  logic              mem_to_regX,
  input  logic [REG_AW-1:0] rr1_reg_X,
  input  logic [REG_AW-1:0] rr2_reg_X,
  input  logic              i_cache_busy,
  input  logic              d_cache_busy,
  output logic              stallFD,
  output logic              stallDX,
  output logic              stallXM,
  output logic              bubbleX,
  output logic [1:0]        forwardD,
  output logic [1:0]        forward_A_selX,
  output logic [1:0]        forward_B_selX,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [REG_AW-1:0] mc_rd,
  output logic [CNT_W-1:0]  stall_cycles
);
  localparam int NR = 2**REG_AW;
  localparam logic [3:0] CNT_LOAD = 4'(MC_LAT-1);
  logic [NR-1:0]     pending_q, pending_d;
  logic              mc_busy_q, mc_busy_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] mc_rd_q, mc_rd_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              load_haz, sb_haz, struct_haz, data_stall, issue_mc;

  function automatic logic match(input logic en, input logic [REG_AW-1:0] wr, input logic [REG_AW-1:0] r);
    return en && (wr == r) && (r != '0);
  endfunction

  // Operand forwarding selects; nearest producing stage wins
  always_comb begin
    forwardD       = match(reg_wr_enX, write_regX, dec_rs1) ? 2'b01 :
                     match(reg_wr_enM, write_regM, dec_rs1) ? 2'b10 :
                     match(reg_wr_enW, write_regW, dec_rs1) ? 2'b11 : 2'b00;
    forward_A_selX = match(reg_wr_enM, write_regM, rr1_reg_X) ? 2'b01 :
                     match(reg_wr_enW, write_regW, rr1_reg_X) ? 2'b10 : 2'b00;
    forward_B_selX = match(reg_wr_enM, write_regM, rr2_reg_X) ? 2'b01 :
                     match(reg_wr_enW, write_regW, rr2_reg_X) ? 2'b10 : 2'b00;
  end

  // Hazard detection and pipeline hold/bubble control
  always_comb begin
    load_haz   = mem_to_regX && (write_regX != '0) &&
                 ((dec_rs1_used && dec_rs1 == write_regX) || (dec_rs2_used && dec_rs2 == write_regX));
    sb_haz     = dec_valid && ((dec_rs1_used && pending_q[dec_rs1]) ||
                               (dec_rs2_used && pending_q[dec_rs2]) ||
                               (dec_wr_en && pending_q[dec_rd]));
    struct_haz = dec_valid && dec_is_mc && mc_busy_q;
    data_stall = load_haz || sb_haz || struct_haz;
    stallFD    = data_stall || i_cache_busy || d_cache_busy;
    stallDX    = d_cache_busy;
    stallXM    = d_cache_busy;
    bubbleX    = data_stall && !d_cache_busy && !flush;
    issue_mc   = dec_valid && !stallFD && !flush && dec_is_mc;
    mc_done    = mc_busy_q && (cnt_q == 4'd0);
  end

  // Next state: the done edge clears the finishing op's pending bit before a new issue can set one
  always_comb begin
    pending_d = pending_q;
    if (mc_done) pending_d[mc_rd_q] = 1'b0;
    if (issue_mc && dec_wr_en && dec_rd != '0) pending_d[dec_rd] = 1'b1;
    mc_busy_d = issue_mc ? 1'b1 : (mc_done ? 1'b0 : mc_busy_q);
    cnt_d     = issue_mc ? CNT_LOAD : ((mc_busy_q && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q);
    mc_rd_d   = issue_mc ? dec_rd : mc_rd_q;
    stall_d   = (stallFD && stall_q != {CNT_W{1'b1}}) ? stall_q + CNT_W'(1) : stall_q;
  end

  // State registers, cleared asynchronously so an in-flight op is discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      mc_busy_q <= 1'b0;
      cnt_q     <= 4'd0;
      mc_rd_q   <= '0;
      stall_q   <= '0;
    end else begin
      pending_q <= pending_d;
      mc_busy_q <= mc_busy_d;
      cnt_q     <= cnt_d;
      mc_rd_q   <= mc_rd_d;
      stall_q   <= stall_d;
    end
  end

  assign mc_busy      = mc_busy_q;
  assign mc_rd        = mc_rd_q;
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table vectors, directed multi-cycle sequences and randomized model comparison
module tb_hazard_scoreboard;
  localparam int AW = 4, LAT = 4, CW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic dec_valid, dec_rs1_used, dec_rs2_used, dec_wr_en, dec_is_mc, flush;
  logic [AW-1:0] dec_rs1, dec_rs2, dec_rd, write_regX, write_regM, write_regW, rr1_reg_X, rr2_reg_X, mc_rd;
  logic reg_wr_enX, reg_wr_enM, reg_wr_enW, mem_to_regX, i_cache_busy, d_cache_busy;
  logic stallFD, stallDX, stallXM, bubbleX, mc_busy, mc_done;
  logic [1:0] forwardD, forward_A_selX, forward_B_selX;
  logic [CW-1:0] stall_cycles;
  int vec = 0, miss = 0;

  hazard_scoreboard #(.REG_AW(AW), .MC_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_wr_en(dec_wr_en), .dec_rd(dec_rd),
    .dec_is_mc(dec_is_mc), .flush(flush), .reg_wr_enX(reg_wr_enX), .reg_wr_enM(reg_wr_enM),
    .reg_wr_enW(reg_wr_enW), .write_regX(write_regX), .write_regM(write_regM), .write_regW(write_regW),
    .mem_to_regX(mem_to_regX), .rr1_reg_X(rr1_reg_X), .rr2_reg_X(rr2_reg_X), .i_cache_busy(i_cache_busy),
    .d_cache_busy(d_cache_busy), .stallFD(stallFD), .stallDX(stallDX), .stallXM(stallXM), .bubbleX(bubbleX),
    .forwardD(forwardD), .forward_A_selX(forward_A_selX), .forward_B_selX(forward_B_selX),
    .mc_busy(mc_busy), .mc_done(mc_done), .mc_rd(mc_rd), .stall_cycles(stall_cycles));

  always #5 clk = ~clk;

  typedef struct {
    logic v, u1, u2, ex, em, ew, ld, ic, dc, fl;
    logic [AW-1:0] rs1, rs2, wx, wm, ww, r1x, r2x;
    logic [1:0] efd, efa, efb;
    logic esfd, ebub, esdx;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    {dec_valid, dec_rs1_used, dec_rs2_used, dec_wr_en, dec_is_mc, flush} = '0;
    {dec_rs1, dec_rs2, dec_rd, write_regX, write_regM, write_regW, rr1_reg_X, rr2_reg_X} = '0;
    {reg_wr_enX, reg_wr_enM, reg_wr_enW, mem_to_regX, i_cache_busy, d_cache_busy} = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic put_mc(input logic [AW-1:0] rd);
    idle();
    dec_valid = 1'b1; dec_is_mc = 1'b1; dec_wr_en = 1'b1; dec_rd = rd;
  endtask

  function automatic logic mt(input logic en, input logic [AW-1:0] w, input logic [AW-1:0] r);
    return en && w == r && r != 0;
  endfunction

  // reference model: at most one multi-cycle op can be in flight, so the scoreboard is just that op
  bit inf, inf_wr;
  int cyc, iss, scnt;
  logic [AW-1:0] inf_rd, last_rd;

  function automatic logic pend(input logic [AW-1:0] r);
    return inf && inf_wr && r == inf_rd;
  endfunction

  initial begin
    idle();
    tbl[0]  = '{v:1'b0, u1:1'b0, u2:1'b0, ex:1'b0, em:1'b0, ew:1'b0, ld:1'b0, ic:1'b0, dc:1'b0, fl:1'b0, rs1:4'd0, rs2:4'd0, wx:4'd0, wm:4'd0, ww:4'd0, r1x:4'd0, r2x:4'd0, efd:2'b00, efa:2'b00, efb:2'b00, esfd:1'b0, ebub:1'b0, esdx:1'b0};
    tbl[1]  = '{v:1'b1, u1:1'b1, u2:1'b0, ex:1'b1, em:1'b1, ew:1'b0, ld:1'b0, ic:1'b0, dc:1'b0, fl:1'b0, rs1:4'd7, rs2:4'd0, wx:4'd7, wm:4'd7, ww:4'd0, r1x:4'd7, r2x:4'd7, efd:2'b01, efa:2'b01, efb:2'b01, esfd:1'b0, ebub:1'b0, esdx:1'b0};
    tbl[2]  = '{v:1'b1, u1:1'b1, u2:1'b0, ex:1'b1, em:1'b1, ew:1'b1, ld:1'b0, ic:1'b0, dc:1'b0, fl:1'b0, rs1:4'd0, rs2:4'd0, wx:4'd0, wm:4'd0, ww:4'd0, r1x:4'd0, r2x:4'd0, efd:2'b00, efa:2'b00, efb:2'b00, esfd:1'b0, ebub:1'b0, esdx:1'b0};
    tbl[3]  = '{v:1'b1, u1:1'b1, u2:1'b0, ex:1'b0, em:1'b0, ew:1'b1, ld:1'b0, ic:1'b0, dc:1'b0, fl:1'b0, rs1:4'd3, rs2:4'd0, wx:4'd3, wm:4'd3, ww:4'd3, r1x:4'd3, r2x:4'd5, efd:2'b11, efa:2'b10, efb:2'b00, esfd:1'b0, ebub:1'b0, esdx:1'b0};
    tbl[4]  = '{v:1'b1, u1:1'b1, u2:1'b0, ex:1'b0, em:1'b1, ew:1'b1, ld:1'b0, ic:1'b0, dc:1'b0, fl:1'b0, rs1:4'd3, rs2:4'd0, wx:4'd3, wm:4'd3, ww:4'd3, r1x:4'd3, r2x:4'd3, efd:2'b10, efa:2'b01, efb:2'b01, esfd:1'b0, ebub:1'b0, esdx:1'b0};
    tbl[5]  = '{v:1'b1, u1:1'b0, u2:1'b1, ex:1'b1, em:1'b0, ew:1'b0, ld:1'b1, ic:1'b0, dc:1'b0, fl:1'b0, rs1:4'd0, rs2:4'd3, wx:4'd3, wm:4'd0, ww:4'd0, r1x:4'd0, r2x:4'd0, efd:2'b00, efa:2'b00, efb:2'b00, esfd:1'b1, ebub:1'b1, esdx:1'b0};
    tbl[6]  = '{v:1'b1, u1:1'b0, u2:1'b0, ex:1'b1, em:1'b0, ew:1'b0, ld:1'b1, ic:1'b0, dc:1'b0, fl:1'b0, rs1:4'd0, rs2:4'd3, wx:4'd3, wm:4'd0, ww:4'd0, r1x:4'd0, r2x:4'd0, efd:2'b00, efa:2'b00, efb:2'b00, esfd:1'b0, ebub:1'b0, esdx:1'b0};
    tbl[7]  = '{v:1'b1, u1:1'b1, u2:1'b0, ex:1'b1, em:1'b0, ew:1'b0, ld:1'b1, ic:1'b0, dc:1'b0, fl:1'b1, rs1:4'd3, rs2:4'd0, wx:4'd3, wm:4'd0, ww:4'd0, r1x:4'd0, r2x:4'd0, efd:2'b01, efa:2'b00, efb:2'b00, esfd:1'b1, ebub:1'b0, esdx:1'b0};
    tbl[8]  = '{v:1'b1, u1:1'b1, u2:1'b0, ex:1'b1, em:1'b0, ew:1'b0, ld:1'b1, ic:1'b0, dc:1'b1, fl:1'b0, rs1:4'd3, rs2:4'd0, wx:4'd3, wm:4'd0, ww:4'd0, r1x:4'd0, r2x:4'd0, efd:2'b01, efa:2'b00, efb:2'b00, esfd:1'b1, ebub:1'b0, esdx:1'b1};
    tbl[9]  = '{v:1'b0, u1:1'b0, u2:1'b0, ex:1'b0, em:1'b0, ew:1'b0, ld:1'b0, ic:1'b1, dc:1'b0, fl:1'b0, rs1:4'd0, rs2:4'd0, wx:4'd0, wm:4'd0, ww:4'd0, r1x:4'd0, r2x:4'd0, efd:2'b00, efa:2'b00, efb:2'b00, esfd:1'b1, ebub:1'b0, esdx:1'b0};
    tbl[10] = '{v:1'b1, u1:1'b1, u2:1'b1, ex:1'b1, em:1'b0, ew:1'b0, ld:1'b1, ic:1'b0, dc:1'b0, fl:1'b0, rs1:4'd0, rs2:4'd0, wx:4'd0, wm:4'd0, ww:4'd0, r1x:4'd0, r2x:4'd0, efd:2'b00, efa:2'b00, efb:2'b00, esfd:1'b0, ebub:1'b0, esdx:1'b0};

    #1;
    chk("reset mc_busy", 32'(mc_busy), 0);
    chk("reset mc_done", 32'(mc_done), 0);
    chk("reset mc_rd", 32'(mc_rd), 0);
    chk("reset stall_cycles", 32'(stall_cycles), 0);
    chk("reset stallFD", 32'(stallFD), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      idle();
      dec_valid = tbl[i].v; dec_rs1_used = tbl[i].u1; dec_rs2_used = tbl[i].u2;
      reg_wr_enX = tbl[i].ex; reg_wr_enM = tbl[i].em; reg_wr_enW = tbl[i].ew; mem_to_regX = tbl[i].ld;
      i_cache_busy = tbl[i].ic; d_cache_busy = tbl[i].dc; flush = tbl[i].fl;
      dec_rs1 = tbl[i].rs1; dec_rs2 = tbl[i].rs2; write_regX = tbl[i].wx; write_regM = tbl[i].wm;
      write_regW = tbl[i].ww; rr1_reg_X = tbl[i].r1x; rr2_reg_X = tbl[i].r2x;
      #1;
      chk($sformatf("tbl%0d forwardD", i), 32'(forwardD), 32'(tbl[i].efd));
      chk($sformatf("tbl%0d fwdA", i), 32'(forward_A_selX), 32'(tbl[i].efa));
      chk($sformatf("tbl%0d fwdB", i), 32'(forward_B_selX), 32'(tbl[i].efb));
      chk($sformatf("tbl%0d stallFD", i), 32'(stallFD), 32'(tbl[i].esfd));
      chk($sformatf("tbl%0d bubbleX", i), 32'(bubbleX), 32'(tbl[i].ebub));
      chk($sformatf("tbl%0d stallDX", i), 32'(stallDX), 32'(tbl[i].esdx));
      chk($sformatf("tbl%0d stallXM", i), 32'(stallXM), 32'(tbl[i].esdx));
    end

    // load-use: one stall/bubble, then the ADD in EX forwards from MEM
    do_reset();
    mem_to_regX = 1'b1; reg_wr_enX = 1'b1; write_regX = 4'd3;
    dec_valid = 1'b1; dec_rs1 = 4'd3; dec_rs1_used = 1'b1; dec_wr_en = 1'b1; dec_rd = 4'd4;
    #1;
    chk("lu stallFD", 32'(stallFD), 1);
    chk("lu bubbleX", 32'(bubbleX), 1);
    @(negedge clk);
    idle();
    reg_wr_enM = 1'b1; write_regM = 4'd3; rr1_reg_X = 4'd3;
    #1;
    chk("lu next stallFD", 32'(stallFD), 0);
    chk("lu next fwdA", 32'(forward_A_selX), 32'b01);

    // mc op to R5 then a reader of R5: stalls MC_LAT cycles, done on the last one
    do_reset();
    put_mc(4'd5);
    #1;
    chk("mc issue stallFD", 32'(stallFD), 0);
    @(negedge clk);
    idle();
    dec_valid = 1'b1; dec_rs1 = 4'd5; dec_rs1_used = 1'b1; dec_wr_en = 1'b1; dec_rd = 4'd6;
    for (int k = 1; k <= LAT; k++) begin
      #1;
      chk($sformatf("raw c%0d stallFD", k), 32'(stallFD), 1);
      chk($sformatf("raw c%0d mc_done", k), 32'(mc_done), 32'(k == LAT));
      chk($sformatf("raw c%0d mc_rd", k), 32'(mc_rd), 5);
      @(negedge clk);
    end
    #1;
    chk("raw release stallFD", 32'(stallFD), 0);
    chk("raw release mc_busy", 32'(mc_busy), 0);
    chk("raw stall_cycles", 32'(stall_cycles), LAT);

    // back-to-back mc ops: second waits for the first's done cycle, issues at the next edge
    do_reset();
    put_mc(4'd2);
    @(negedge clk);
    put_mc(4'd6);
    for (int k = 1; k <= LAT; k++) begin
      #1;
      chk($sformatf("b2b c%0d stallFD", k), 32'(stallFD), 1);
      chk($sformatf("b2b c%0d mc_done", k), 32'(mc_done), 32'(k == LAT));
      @(negedge clk);
    end
    #1;
    chk("b2b issue stallFD", 32'(stallFD), 0);
    @(negedge clk);
    idle();
    #1;
    chk("b2b second busy", 32'(mc_busy), 1);
    chk("b2b second rd", 32'(mc_rd), 6);

    // d-cache miss with load hazard: full hold, no bubble, mc countdown unaffected
    do_reset();
    put_mc(4'd9);
    @(negedge clk);
    idle();
    d_cache_busy = 1'b1; mem_to_regX = 1'b1; reg_wr_enX = 1'b1; write_regX = 4'd3;
    dec_valid = 1'b1; dec_rs2 = 4'd3; dec_rs2_used = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      #1;
      chk($sformatf("dc c%0d stallFD", k), 32'(stallFD), 1);
      chk($sformatf("dc c%0d stallDX", k), 32'(stallDX), 1);
      chk($sformatf("dc c%0d stallXM", k), 32'(stallXM), 1);
      chk($sformatf("dc c%0d bubbleX", k), 32'(bubbleX), 0);
      chk($sformatf("dc c%0d mc_done", k), 32'(mc_done), 32'(k == LAT));
      @(negedge clk);
    end

    // asynchronous reset mid-op discards it
    do_reset();
    put_mc(4'd5);
    @(negedge clk);
    idle();
    dec_valid = 1'b1; dec_rs1 = 4'd5; dec_rs1_used = 1'b1;
    @(negedge clk);
    #1;
    chk("arst pre stallFD", 32'(stallFD), 1);
    rst = 1'b1;
    #1;
    chk("arst mc_busy", 32'(mc_busy), 0);
    chk("arst stallFD", 32'(stallFD), 0);
    chk("arst stall_cycles", 32'(stall_cycles), 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    for (int k = 0; k < LAT + 2; k++) begin
      #1;
      chk($sformatf("arst post%0d mc_done", k), 32'(mc_done), 0);
      @(negedge clk);
    end

    // stall counter saturates instead of wrapping
    do_reset();
    i_cache_busy = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("sat stall_cycles", 32'(stall_cycles), (1 << CW) - 1);

    // randomized run against the model
    do_reset();
    inf = 0; inf_wr = 0; cyc = 0; iss = 0; scnt = 0; inf_rd = '0; last_rd = '0;
    for (int n = 0; n < 2000; n++) begin
      logic lh, sb, st, ds, sfd, done, iss_now;
      logic [1:0] efd, efa, efb;
      @(negedge clk);
      dec_valid = $urandom_range(0, 9) < 8; dec_rs1_used = $urandom_range(0, 1) == 1;
      dec_rs2_used = $urandom_range(0, 1) == 1; dec_wr_en = $urandom_range(0, 3) != 0;
      dec_is_mc = $urandom_range(0, 9) < 3; flush = $urandom_range(0, 9) == 0;
      reg_wr_enX = $urandom_range(0, 1) == 1; reg_wr_enM = $urandom_range(0, 1) == 1;
      reg_wr_enW = $urandom_range(0, 1) == 1; mem_to_regX = $urandom_range(0, 9) < 3;
      i_cache_busy = $urandom_range(0, 9) == 0; d_cache_busy = $urandom_range(0, 9) == 0;
      dec_rs1 = 4'($urandom_range(0, 7)); dec_rs2 = 4'($urandom_range(0, 7)); dec_rd = 4'($urandom_range(0, 7));
      write_regX = 4'($urandom_range(0, 7)); write_regM = 4'($urandom_range(0, 7));
      write_regW = 4'($urandom_range(0, 7)); rr1_reg_X = 4'($urandom_range(0, 7)); rr2_reg_X = 4'($urandom_range(0, 7));
      #1;
      efd = mt(reg_wr_enX, write_regX, dec_rs1) ? 2'b01 : mt(reg_wr_enM, write_regM, dec_rs1) ? 2'b10 :
            mt(reg_wr_enW, write_regW, dec_rs1) ? 2'b11 : 2'b00;
      efa = mt(reg_wr_enM, write_regM, rr1_reg_X) ? 2'b01 : mt(reg_wr_enW, write_regW, rr1_reg_X) ? 2'b10 : 2'b00;
      efb = mt(reg_wr_enM, write_regM, rr2_reg_X) ? 2'b01 : mt(reg_wr_enW, write_regW, rr2_reg_X) ? 2'b10 : 2'b00;
      lh = mem_to_regX && write_regX != 0 && ((dec_rs1_used && dec_rs1 == write_regX) || (dec_rs2_used && dec_rs2 == write_regX));
      sb = dec_valid && ((dec_rs1_used && pend(dec_rs1)) || (dec_rs2_used && pend(dec_rs2)) || (dec_wr_en && pend(dec_rd)));
      st = dec_valid && dec_is_mc && inf;
      ds = lh || sb || st;
      sfd = ds || i_cache_busy || d_cache_busy;
      done = inf && (cyc - iss == LAT - 1);
      chk("rnd forwardD", 32'(forwardD), 32'(efd));
      chk("rnd fwdA", 32'(forward_A_selX), 32'(efa));
      chk("rnd fwdB", 32'(forward_B_selX), 32'(efb));
      chk("rnd stallFD", 32'(stallFD), 32'(sfd));
      chk("rnd stallDX", 32'(stallDX), 32'(d_cache_busy));
      chk("rnd bubbleX", 32'(bubbleX), 32'(ds && !d_cache_busy && !flush));
      chk("rnd mc_busy", 32'(mc_busy), 32'(inf));
      chk("rnd mc_done", 32'(mc_done), 32'(done));
      chk("rnd mc_rd", 32'(mc_rd), 32'(last_rd));
      chk("rnd stall_cycles", 32'(stall_cycles), scnt);
      iss_now = dec_valid && !sfd && !flush && dec_is_mc;
      cyc++;
      if (done) inf = 0;
      if (iss_now) begin
        inf = 1; iss = cyc; inf_rd = dec_rd; inf_wr = dec_wr_en && dec_rd != 0; last_rd = dec_rd;
      end
      if (sfd && scnt < (1 << CW) - 1) scnt++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
